renode_axi_manager_engine: RTL and testbench
============================================

Name: renode_axi_manager_engine

Overview:
- Synthesizable AXI4 manager (initiator) that turns simple commands into single INCR bursts on an AXI bus. It is the counterpart of the Renode AXI subordinate model.
- Sits between a Renode-driven or HDL command source and any AXI subordinate under test.
- One transaction outstanding at a time.
- Reports completion status and flags protocol violations seen on the responder side.

Parameters:
- AddressWidth, 32, width of cmd_addr, awaddr and araddr.
- DataWidth, 32, data width of every data port; must be a power of two and at least 8; StrobeWidth = DataWidth/8.
- TransactionIdWidth, 8, width of the ID fields.

Ports:
- aclk  in  1  clock
- areset_n  in  1  reset; asynchronous assert, active-low
- cmd_valid/cmd_ready  in/out  1/1  command handshake
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  AddressWidth  burst start address
- cmd_len  in  8  beats minus one
- cmd_size  in  3  log2 of bytes per beat
- cmd_id  in  TransactionIdWidth  transaction ID
- wr_valid/wr_ready  in/out  1/1  write-data stream handshake
- wr_data/wr_strb  in  DataWidth/StrobeWidth  write beat and its strobes
- rd_valid/rd_ready  out/in  1/1  read-data stream handshake
- rd_data  out  DataWidth  read beat
- rd_last  out  1  final read beat
- done_valid  out  1  one-cycle completion pulse
- done_resp  out  2  worst response of the burst
- done_proto_err  out  1  protocol violation seen
- awid/awaddr/awlen/awsize/awburst/awvalid  out  AXI write-address channel
- awready  in  1
- wdata/wstrb/wlast/wvalid  out  AXI write-data channel
- wready  in  1
- bid/bresp/bvalid  in  AXI write-response channel
- bready  out  1
- arid/araddr/arlen/arsize/arburst/arvalid  out  AXI read-address channel
- arready  in  1
- rid/rdata/rresp/rlast/rvalid  in  AXI read-data channel
- rready  out  1

Behaviour:
- FSM states: IDLE, AW, W, B, AR, R, DONE.
- Reset (async, areset_n=0):
  - FSM enters IDLE; beat counter and sticky flags clear.
  - Outputs: awvalid=wvalid=bready=arvalid=rready=0, done_valid=0, rd_valid=0, cmd_ready=0.
  - All registered address, ID and length outputs go to 0.
- Reset mid-burst aborts the burst with no done pulse. Once reset deasserts, cmd_ready rises on the first aclk edge.
- IDLE:
  - cmd_ready=1; a command is accepted on an edge with cmd_valid=1.
  - Validation happens at acceptance. The command is rejected if any of these hold:
    - cmd_addr is not aligned to 2^cmd_size;
    - 2^cmd_size > StrobeWidth;
    - the burst crosses a 4 KiB boundary, i.e. (cmd_addr & 0xFFF) + (cmd_len+1)*2^cmd_size > 4096.
  - Rejected command: no bus activity, go to DONE with done_resp=2'b10 and done_proto_err=0.
  - Accepted command: go to AW if cmd_write=1, else AR.
- Address registers (both channels):
  - AXI address fields are registered from the command; awburst=arburst=2'b01.
  - awvalid/arvalid rise on the cycle after acceptance and are held, with stable payload, until the edge with the matching ready=1.
  - Next state after that edge: AW goes to W, AR goes to R.
- W state:
  - wvalid=wr_valid, wr_ready=wready, wdata=wr_data, wstrb=wr_strb (combinational pass-through, zero latency).
  - Beat counter increments on each wvalid&&wready edge.
  - wlast=1 exactly when counter==cmd_len.
  - After the last beat transfers, go to B.
  - wvalid is never driven in AW. Write data is not overlapped with the address phase.
- B state:
  - bready=1; on bvalid, capture bresp.
  - bid != the registered ID sets proto_err.
  - Go to DONE.
- R state:
  - rd_valid=rvalid, rready=rd_ready, rd_data=rdata, rd_last=(counter==cmd_len).
  - On each rvalid&&rready edge: counter increments, and done_resp=max(done_resp, rresp).
  - Any of these sets proto_err: rid != the registered ID; rlast != (counter==cmd_len).
  - After beat cmd_len, go to DONE.
- DONE:
  - done_valid=1 for exactly one cycle with the final done_resp/done_proto_err, then IDLE.
  - cmd_ready=0 in DONE, so the minimum command-to-command spacing is one DONE cycle.
- Counter is 9 bits, so cmd_len=255 (256 beats) cannot overflow.
- done_resp and done_proto_err hold their values until the next command is accepted.
- The module never drops a valid before its handshake completes.

Test Plan:
- Single write: addr 0x100, len 0, size 2, data 0xDEADBEEF; awready high -> awvalid one cycle after acceptance, one W beat with wlast=1, bresp 0 -> done_valid pulse, done_resp=0.
- 4-beat read: addr 0x40, len 3, size 2; subordinate returns 1,2,3,4 with rlast on beat 4 -> rd_data 1..4, rd_last only on beat 4, done_resp=0, proto_err=0.
- Backpressure: awready delayed 5 cycles, wready toggling every cycle, rd_ready low 3 cycles mid-read -> payloads stable while stalled; beat counts exact; no lost or duplicated beats.
- Rejects: addr 0x102 with size 2; addr 0xFF0, len 7, size 2 (crosses 4 KiB) -> no aw/ar valid ever, done_resp=2'b10 in the cycle after acceptance.
- Error/protocol: read len 1 with rresp=SLVERR on beat 0 and rlast asserted early on beat 0 -> done_resp=2'b10, proto_err=1; write with bid mismatch -> proto_err=1.
- Reset mid-burst: assert areset_n=0 during beat 2 of an 8-beat write -> wvalid=0 immediately (asynchronously), no done pulse; next command completes normally.

Source files
------------

// File: rtl/renode_axi_manager_engine_if.sv
// ---------------------------------------------------------------------------
// renode_axi_manager_engine_if
//
// Purpose:
//   Groups every handshake and bus signal of the AXI manager engine into one
//   bundle. The bundle has three parts:
//     - the command, write-stream, read-stream and completion side, which
//       faces the command source;
//     - the five AXI4 channels, which face the subordinate under test;
//     - the parameters shared by both parts.
//
// Modports:
//   master : the engine's view. It receives commands, write beats and AXI
//            responses, and drives the AXI requests, read beats and
//            completion status.
//   slave  : the environment's view, i.e. the command source plus the
//            subordinate. Every direction is the reverse of master.
//
// Parameters:
//   AddressWidth       : width of cmd_addr, awaddr and araddr
//   DataWidth          : width of all data ports (power of two, >= 8)
//   TransactionIdWidth : width of the ID fields
// ---------------------------------------------------------------------------
interface renode_axi_manager_engine_if #(
  parameter int AddressWidth       = 32,
  parameter int DataWidth          = 32,
  parameter int TransactionIdWidth = 8
);
  localparam int StrobeWidth = DataWidth / 8;

  // Command handshake
  logic                          cmd_valid;
  logic                          cmd_ready;
  logic                          cmd_write;
  logic [AddressWidth-1:0]       cmd_addr;
  logic [7:0]                    cmd_len;
  logic [2:0]                    cmd_size;
  logic [TransactionIdWidth-1:0] cmd_id;

  // Write-data stream from the command source
  logic                          wr_valid;
  logic                          wr_ready;
  logic [DataWidth-1:0]          wr_data;
  logic [StrobeWidth-1:0]        wr_strb;

  // Read-data stream towards the command source
  logic                          rd_valid;
  logic                          rd_ready;
  logic [DataWidth-1:0]          rd_data;
  logic                          rd_last;

  // Completion status
  logic                          done_valid;
  logic [1:0]                    done_resp;
  logic                          done_proto_err;

  // AXI write-address channel
  logic [TransactionIdWidth-1:0] awid;
  logic [AddressWidth-1:0]       awaddr;
  logic [7:0]                    awlen;
  logic [2:0]                    awsize;
  logic [1:0]                    awburst;
  logic                          awvalid;
  logic                          awready;

  // AXI write-data channel
  logic [DataWidth-1:0]          wdata;
  logic [StrobeWidth-1:0]        wstrb;
  logic                          wlast;
  logic                          wvalid;
  logic                          wready;

  // AXI write-response channel
  logic [TransactionIdWidth-1:0] bid;
  logic [1:0]                    bresp;
  logic                          bvalid;
  logic                          bready;

  // AXI read-address channel
  logic [TransactionIdWidth-1:0] arid;
  logic [AddressWidth-1:0]       araddr;
  logic [7:0]                    arlen;
  logic [2:0]                    arsize;
  logic [1:0]                    arburst;
  logic                          arvalid;
  logic                          arready;

  // AXI read-data channel
  logic [TransactionIdWidth-1:0] rid;
  logic [DataWidth-1:0]          rdata;
  logic [1:0]                    rresp;
  logic                          rlast;
  logic                          rvalid;
  logic                          rready;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_size, cmd_id,
    output cmd_ready,
    input  wr_valid, wr_data, wr_strb,
    output wr_ready,
    output rd_valid, rd_data, rd_last,
    input  rd_ready,
    output done_valid, done_resp, done_proto_err,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_size, cmd_id,
    input  cmd_ready,
    output wr_valid, wr_data, wr_strb,
    input  wr_ready,
    input  rd_valid, rd_data, rd_last,
    output rd_ready,
    input  done_valid, done_resp, done_proto_err,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/renode_axi_manager_engine.sv
// ---------------------------------------------------------------------------
// renode_axi_manager_engine
//
// Purpose:
//   AXI4 manager that turns one simple command into one INCR burst. Only one
//   transaction is outstanding at a time.
//
//   Commands are checked when they are accepted. A command is rejected when:
//     - its address is misaligned,
//     - its beat size is too wide for the data bus, or
//     - its burst crosses a 4 KiB boundary.
//   A rejected command never reaches the bus and completes with SLVERR.
//
//   Write beats flow straight from the wr_* stream to the AXI W channel.
//   Read beats flow straight from the AXI R channel to the rd_* stream.
//
//   Completion is a one-cycle done_valid pulse. It carries:
//     - the worst response seen during the burst, and
//     - a flag for responder protocol violations (ID mismatch, misplaced
//       rlast).
//
// Ports:
//   aclk_i     : clock
//   areset_n_i : asynchronous, active-low reset
//   bus_io     : renode_axi_manager_engine_if.master. It carries the command,
//                write-stream, read-stream and completion signals, plus all
//                five AXI channels.
// ---------------------------------------------------------------------------
module renode_axi_manager_engine #(
  parameter int AddressWidth       = 32,
  parameter int DataWidth          = 32,
  parameter int TransactionIdWidth = 8
) (
  input logic                         aclk_i,
  input logic                         areset_n_i,
  renode_axi_manager_engine_if.master bus_io
);
  localparam int StrobeWidth = DataWidth / 8;

  typedef enum logic [2:0] {
    IDLE,
    AW,
    W,
    B,
    AR,
    R,
    DONE
  } state_e;

  state_e                        state_q, state_d;
  logic                          readyArm_q;
  logic [AddressWidth-1:0]       addr_q, addr_d;
  logic [7:0]                    len_q, len_d;
  logic [2:0]                    size_q, size_d;
  logic [TransactionIdWidth-1:0] id_q, id_d;
  logic [8:0]                    beatCount_q, beatCount_d;
  logic [1:0]                    doneResp_q, doneResp_d;
  logic                          protoErr_q, protoErr_d;

  logic        cmdFire;
  logic        cmdReject;
  logic        lastBeat;
  logic        wFire;
  logic        rFire;
  logic [31:0] sizeBytes;
  logic [31:0] burstEnd;
  logic        misaligned;
  logic        tooWide;
  logic        crosses4k;

  // Command validation is evaluated on the raw command inputs so that the
  // accept/reject decision is made on the same edge that accepts the command.
  // Only the low 12 address bits matter for both alignment and the 4 KiB
  // check. The arithmetic is done at 32 bits, so the largest possible burst
  // end (4095 + 256 * 128) cannot wrap.
  always_comb begin
    sizeBytes  = 32'd1 << bus_io.cmd_size;
    misaligned = ({20'd0, bus_io.cmd_addr[11:0]} & (sizeBytes - 32'd1)) != 32'd0;
    tooWide    = sizeBytes > 32'(StrobeWidth);
    burstEnd   = {20'd0, bus_io.cmd_addr[11:0]}
               + ((32'(bus_io.cmd_len) + 32'd1) << bus_io.cmd_size);
    crosses4k  = burstEnd > 32'd4096;
    cmdReject  = misaligned | tooWide | crosses4k;
  end

  // readyArm_q keeps cmd_ready low until the first clock edge after reset is
  // released. Without it, cmd_ready would follow the reset state of the FSM.
  assign cmdFire  = (state_q == IDLE) && readyArm_q && bus_io.cmd_valid;
  assign lastBeat = (beatCount_q == {1'b0, len_q});
  assign wFire    = (state_q == W) && bus_io.wr_valid && bus_io.wready;
  assign rFire    = (state_q == R) && bus_io.rvalid && bus_io.rd_ready;

  // State register. Reset drops straight back to IDLE, which abandons any
  // burst in flight without producing a done pulse.
  always_ff @(posedge aclk_i or negedge areset_n_i) begin
    if (!areset_n_i) begin
      state_q    <= IDLE;
      readyArm_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      readyArm_q <= 1'b1;
    end
  end

  // Next-state logic.
  // Each bus phase moves on only after its own handshake completes, so
  // address and data are never overlapped.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (cmdFire) begin
          if (cmdReject) begin
            state_d = DONE;
          end else if (bus_io.cmd_write) begin
            state_d = AW;
          end else begin
            state_d = AR;
          end
        end
      end
      AW:      if (bus_io.awready) state_d = W;
      W:       if (wFire && lastBeat) state_d = B;
      B:       if (bus_io.bvalid) state_d = DONE;
      AR:      if (bus_io.arready) state_d = R;
      R:       if (rFire && lastBeat) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic. Valids and readies are decoded purely from the state, and
  // the data-stream handshakes are passed through only in their own phase.
  // Because of that decoding, an asynchronous reset removes them at once.
  always_comb begin
    bus_io.cmd_ready  = 1'b0;
    bus_io.awvalid    = 1'b0;
    bus_io.wvalid     = 1'b0;
    bus_io.wr_ready   = 1'b0;
    bus_io.wlast      = 1'b0;
    bus_io.bready     = 1'b0;
    bus_io.arvalid    = 1'b0;
    bus_io.rready     = 1'b0;
    bus_io.rd_valid   = 1'b0;
    bus_io.rd_last    = 1'b0;
    bus_io.done_valid = 1'b0;
    unique case (state_q)
      IDLE: bus_io.cmd_ready = readyArm_q;
      AW:   bus_io.awvalid = 1'b1;
      W: begin
        bus_io.wvalid   = bus_io.wr_valid;
        bus_io.wr_ready = bus_io.wready;
        bus_io.wlast    = lastBeat;
      end
      B:    bus_io.bready = 1'b1;
      AR:   bus_io.arvalid = 1'b1;
      R: begin
        bus_io.rd_valid = bus_io.rvalid;
        bus_io.rready   = bus_io.rd_ready;
        bus_io.rd_last  = lastBeat;
      end
      DONE: bus_io.done_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath next-state logic.
  // The command fields are captured at acceptance, and so are the cleared
  // status and beat counter. The status bits are sticky across the burst:
  //   - the response keeps its worst value;
  //   - the protocol error flag, once set, stays set.
  // Both hold until the next command is accepted.
  always_comb begin
    addr_d      = addr_q;
    len_d       = len_q;
    size_d      = size_q;
    id_d        = id_q;
    beatCount_d = beatCount_q;
    doneResp_d  = doneResp_q;
    protoErr_d  = protoErr_q;
    unique case (state_q)
      IDLE: begin
        if (cmdFire) begin
          addr_d      = bus_io.cmd_addr;
          len_d       = bus_io.cmd_len;
          size_d      = bus_io.cmd_size;
          id_d        = bus_io.cmd_id;
          beatCount_d = 9'd0;
          doneResp_d  = cmdReject ? 2'b10 : 2'b00;
          protoErr_d  = 1'b0;
        end
      end
      W: begin
        if (wFire) beatCount_d = beatCount_q + 9'd1;
      end
      B: begin
        if (bus_io.bvalid) begin
          doneResp_d = bus_io.bresp;
          if (bus_io.bid != id_q) protoErr_d = 1'b1;
        end
      end
      R: begin
        if (rFire) begin
          beatCount_d = beatCount_q + 9'd1;
          if (bus_io.rresp > doneResp_q) doneResp_d = bus_io.rresp;
          if ((bus_io.rid != id_q) || (bus_io.rlast != lastBeat)) protoErr_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers, cleared together with the FSM.
  always_ff @(posedge aclk_i or negedge areset_n_i) begin
    if (!areset_n_i) begin
      addr_q      <= '0;
      len_q       <= '0;
      size_q      <= '0;
      id_q        <= '0;
      beatCount_q <= '0;
      doneResp_q  <= '0;
      protoErr_q  <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      len_q       <= len_d;
      size_q      <= size_d;
      id_q        <= id_d;
      beatCount_q <= beatCount_d;
      doneResp_q  <= doneResp_d;
      protoErr_q  <= protoErr_d;
    end
  end

  // Both address channels share the registered command fields.
  assign bus_io.awid    = id_q;
  assign bus_io.awaddr  = addr_q;
  assign bus_io.awlen   = len_q;
  assign bus_io.awsize  = size_q;
  assign bus_io.awburst = 2'b01;
  assign bus_io.arid    = id_q;
  assign bus_io.araddr  = addr_q;
  assign bus_io.arlen   = len_q;
  assign bus_io.arsize  = size_q;
  assign bus_io.arburst = 2'b01;

  // Zero-latency data pass-through; the valids above qualify these.
  assign bus_io.wdata   = bus_io.wr_data;
  assign bus_io.wstrb   = bus_io.wr_strb;
  assign bus_io.rd_data = bus_io.rdata;

  assign bus_io.done_resp      = doneResp_q;
  assign bus_io.done_proto_err = protoErr_q;
endmodule

// File: tb/tb_renode_axi_manager_engine.sv
// ---------------------------------------------------------------------------
// tb_renode_axi_manager_engine
//
// Purpose:
//   Self-checking bench for renode_axi_manager_engine. A table of directed
//   transactions, each with hand-computed completion status, is driven
//   against a small cycle-level subordinate and command-source model. A few
//   hand-written sequences cover the multi-cycle corner cases:
//     - reset state,
//     - backpressure,
//     - reset in the middle of a burst.
// ---------------------------------------------------------------------------
module tb_renode_axi_manager_engine;
  logic aclk;
  logic areset_n;

  int checks;
  int errors;

  renode_axi_manager_engine_if #(
    .AddressWidth(32),
    .DataWidth(32),
    .TransactionIdWidth(8)
  ) bus ();

  renode_axi_manager_engine #(
    .AddressWidth(32),
    .DataWidth(32),
    .TransactionIdWidth(8)
  ) dut (
    .aclk_i(aclk),
    .areset_n_i(areset_n),
    .bus_io(bus)
  );

  // One directed transaction and its hand-computed outcome.
  typedef struct {
    logic       write;
    logic [31:0] addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [7:0] id;
    logic [1:0] beatResp;
    logic       badId;
    logic       earlyLast;
    logic       expReject;
    logic [1:0] expResp;
    logic       expProto;
    int         expDoneCyc;
  } txnVec_t;

  txnVec_t vecs[10];

  // Free-running clock, 10 time units per period.
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Write-beat payload the source offers for a given beat index.
  function automatic logic [31:0] pattern(input int beat);
    return 32'hDEADBEEF + 32'(beat) * 32'h01010101;
  endfunction

  // Every comparison goes through here so the counters stay in one place.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Returns every input the bench drives to its quiet value.
  task automatic clearInputs();
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.cmd_size  = '0;
    bus.cmd_id    = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    bus.wr_strb   = '0;
    bus.rd_ready  = 1'b1;
    bus.awready   = 1'b0;
    bus.wready    = 1'b0;
    bus.bid       = '0;
    bus.bresp     = '0;
    bus.bvalid    = 1'b0;
    bus.arready   = 1'b0;
    bus.rid       = '0;
    bus.rdata     = '0;
    bus.rresp     = '0;
    bus.rlast     = 1'b0;
    bus.rvalid    = 1'b0;
  endtask

  // Issues one command and then plays subordinate and data source cycle by
  // cycle until done_valid or the cycle budget runs out.
  //   - Inputs are driven at the falling edge.
  //   - Outputs are sampled 1 time unit later, still before the rising edge.
  // Stall controls:
  //   - awDelay     : cycles awvalid must wait before awready is given;
  //   - wToggle     : makes wready alternate every cycle;
  //   - rdStallBeat : holds rd_ready low for 3 cycles at that read beat.
  task automatic applyStimulus(input txnVec_t v, input int awDelay, input bit wToggle,
                               input int rdStallBeat, input string tag);
    int beatsW, beatsR, awHighCyc, arHighCyc, stallCnt, doneCyc;
    bit awDone, arDone, bDone, doneSeen, earlyW;
    int expW, expR, expAw, expAr;
    beatsW = 0; beatsR = 0; awHighCyc = 0; arHighCyc = 0; stallCnt = 0; doneCyc = -1;
    awDone = 0; arDone = 0; bDone = 0; doneSeen = 0; earlyW = 0;

    @(negedge aclk);
    #1;
    checkOutput({tag, " cmd_ready"}, 64'(bus.cmd_ready), 64'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = v.write;
    bus.cmd_addr  = v.addr;
    bus.cmd_len   = v.len;
    bus.cmd_size  = v.size;
    bus.cmd_id    = v.id;
    @(negedge aclk);
    bus.cmd_valid = 1'b0;

    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc > 0) @(negedge aclk);
      bus.awready  = (awHighCyc >= awDelay);
      bus.wr_valid = v.write;
      bus.wr_data  = pattern(beatsW);
      bus.wr_strb  = 4'hF;
      bus.wready   = wToggle ? ((cyc % 2) == 1) : 1'b1;
      bus.bvalid   = v.write && (beatsW == int'(v.len) + 1) && !bDone;
      bus.bid      = v.badId ? (v.id ^ 8'h01) : v.id;
      bus.bresp    = v.beatResp;
      bus.arready  = 1'b1;
      bus.rvalid   = arDone && (beatsR <= int'(v.len));
      bus.rdata    = 32'(beatsR + 1);
      bus.rresp    = (beatsR == 0) ? v.beatResp : 2'b00;
      bus.rlast    = v.earlyLast ? (beatsR == 0) : (beatsR == int'(v.len));
      bus.rid      = v.id;
      bus.rd_ready = !((beatsR == rdStallBeat) && (stallCnt < 3));
      if (!bus.rd_ready && bus.rvalid) stallCnt++;
      #1;
      if (bus.done_valid) begin
        doneSeen = 1;
        doneCyc  = cyc;
        break;
      end
      if (bus.awvalid) begin
        checkOutput({tag, " aw payload"},
                    64'({bus.awaddr, bus.awlen, bus.awsize, bus.awburst, bus.awid}),
                    64'({v.addr, v.len, v.size, 2'b01, v.id}));
        awHighCyc++;
        if (bus.awready) awDone = 1;
      end
      if (bus.wvalid && !awDone) earlyW = 1;
      if (bus.wvalid && bus.wready) begin
        checkOutput({tag, " w beat"}, 64'({bus.wdata, bus.wlast}),
                    64'({pattern(beatsW), beatsW == int'(v.len)}));
        beatsW++;
      end
      if (bus.bvalid && bus.bready) bDone = 1;
      if (bus.arvalid) begin
        checkOutput({tag, " ar payload"},
                    64'({bus.araddr, bus.arlen, bus.arsize, bus.arburst, bus.arid}),
                    64'({v.addr, v.len, v.size, 2'b01, v.id}));
        arHighCyc++;
        if (bus.arready) arDone = 1;
      end
      if (bus.rd_valid) begin
        checkOutput({tag, " rd data"}, 64'(bus.rd_data), 64'(beatsR + 1));
        if (bus.rd_ready) begin
          checkOutput({tag, " rd last"}, 64'(bus.rd_last), 64'(beatsR == int'(v.len)));
          beatsR++;
        end
      end
    end

    checkOutput({tag, " done seen"}, 64'(doneSeen), 64'd1);
    if (doneSeen) begin
      checkOutput({tag, " done resp"}, 64'(bus.done_resp), 64'(v.expResp));
      checkOutput({tag, " proto err"}, 64'(bus.done_proto_err), 64'(v.expProto));
    end
    if (v.expDoneCyc >= 0) checkOutput({tag, " done cycle"}, 64'(doneCyc), 64'(v.expDoneCyc));
    expW  = (v.write && !v.expReject) ? int'(v.len) + 1 : 0;
    expR  = (!v.write && !v.expReject) ? int'(v.len) + 1 : 0;
    expAw = (v.write && !v.expReject) ? awDelay + 1 : 0;
    expAr = (!v.write && !v.expReject) ? 1 : 0;
    checkOutput({tag, " w beats"}, 64'(beatsW), 64'(expW));
    checkOutput({tag, " r beats"}, 64'(beatsR), 64'(expR));
    checkOutput({tag, " awvalid cycles"}, 64'(awHighCyc), 64'(expAw));
    checkOutput({tag, " arvalid cycles"}, 64'(arHighCyc), 64'(expAr));
    checkOutput({tag, " wvalid before aw"}, 64'(earlyW), 64'd0);

    clearInputs();
    @(negedge aclk);
    #1;
    checkOutput({tag, " done pulse width"}, 64'(bus.done_valid), 64'd0);
    checkOutput({tag, " status held"}, 64'({bus.done_resp, bus.done_proto_err}),
                64'({v.expResp, v.expProto}));
  endtask

  // Main sequence: reset checks, the vector table, then the hand-written
  // corner cases, then the summary line.
  initial begin
    //        wr  addr         len    sz    id     resp   badId earlyL rej   eResp  eProto cyc
    vecs[0] = '{1'b1, 32'h0000_0100, 8'd0, 3'd2, 8'h11, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 3};
    vecs[1] = '{1'b0, 32'h0000_0040, 8'd3, 3'd2, 8'h22, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 5};
    vecs[2] = '{1'b1, 32'h0000_0102, 8'd0, 3'd2, 8'h33, 2'b00, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 0};
    vecs[3] = '{1'b0, 32'h0000_0FF0, 8'd7, 3'd2, 8'h44, 2'b00, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 0};
    vecs[4] = '{1'b0, 32'h0000_0080, 8'd1, 3'd2, 8'h55, 2'b10, 1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 3};
    vecs[5] = '{1'b1, 32'h0000_0200, 8'd0, 3'd2, 8'h66, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 3};
    vecs[6] = '{1'b1, 32'h0000_0000, 8'd0, 3'd3, 8'h77, 2'b00, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 0};
    vecs[7] = '{1'b0, 32'h0000_0FF0, 8'd3, 3'd2, 8'h88, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 5};
    vecs[8] = '{1'b1, 32'h0000_0300, 8'd3, 3'd2, 8'h99, 2'b01, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 6};
    vecs[9] = '{1'b0, 32'h0000_0003, 8'd0, 3'd0, 8'hAA, 2'b11, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 2};

    checks = 0;
    errors = 0;
    clearInputs();
    areset_n = 1'b0;

    // Reset state: every valid and ready low, registered fields cleared.
    repeat (3) @(negedge aclk);
    #1;
    checkOutput("reset handshakes",
                64'({bus.cmd_ready, bus.awvalid, bus.wvalid, bus.bready, bus.arvalid,
                     bus.rready, bus.done_valid, bus.rd_valid}), 64'd0);
    checkOutput("reset aw fields", 64'({bus.awaddr, bus.awid, bus.awlen}), 64'd0);
    checkOutput("reset ar fields", 64'({bus.araddr, bus.arid, bus.arlen}), 64'd0);
    checkOutput("reset status", 64'({bus.done_resp, bus.done_proto_err}), 64'd0);
    areset_n = 1'b1;
    #1;
    checkOutput("cmd_ready before first edge", 64'(bus.cmd_ready), 64'd0);
    @(negedge aclk);
    #1;
    checkOutput("cmd_ready after first edge", 64'(bus.cmd_ready), 64'd1);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i], 0, 1'b0, -1, $sformatf("vec%0d", i));
    end

    // Backpressure: slow awready with toggling wready, then a read whose
    // consumer stalls for three cycles at beat 2.
    begin
      txnVec_t bp;
      bp = '{1'b1, 32'h0000_0500, 8'd3, 3'd2, 8'h5A, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, -1};
      applyStimulus(bp, 5, 1'b1, -1, "bp write");
      bp = '{1'b0, 32'h0000_0600, 8'd3, 3'd2, 8'hA5, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, -1};
      applyStimulus(bp, 0, 1'b0, 2, "bp read");
    end

    // Reset during beat 2 of an 8-beat write: wvalid must fall without
    // waiting for a clock edge, and no completion may follow.
    @(negedge aclk);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 32'h0000_0400;
    bus.cmd_len   = 8'd7;
    bus.cmd_size  = 3'd2;
    bus.cmd_id    = 8'h05;
    @(negedge aclk);
    bus.cmd_valid = 1'b0;
    bus.awready   = 1'b1;
    #1;
    checkOutput("midrst awvalid", 64'(bus.awvalid), 64'd1);
    @(negedge aclk);
    bus.awready  = 1'b0;
    bus.wr_valid = 1'b1;
    bus.wr_data  = pattern(0);
    bus.wr_strb  = 4'hF;
    bus.wready   = 1'b1;
    @(negedge aclk);
    bus.wr_data = pattern(1);
    @(negedge aclk);
    bus.wr_data = pattern(2);
    #1;
    checkOutput("midrst wvalid beat2", 64'(bus.wvalid), 64'd1);
    areset_n = 1'b0;
    #1;
    checkOutput("midrst wvalid async", 64'(bus.wvalid), 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge aclk);
      #1;
      checkOutput("midrst no done", 64'(bus.done_valid), 64'd0);
    end
    clearInputs();
    areset_n = 1'b1;
    applyStimulus(vecs[0], 0, 1'b0, -1, "post reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
